// File: rtl/his_pkg.sv
// Shared types, default geometry and arithmetic helpers for the histogram peak builder.
package his_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } his_state_e;

    localparam int NP_DEF        = 10;
    localparam int PIXEL_NUM_DEF = 3;
    localparam int BIN_W_DEF     = 4;
    localparam int CNT_W_DEF     = 8;
    localparam int BIN_NUM       = 2**BIN_W_DEF;
    localparam int DEPTH         = PIXEL_NUM_DEF * BIN_NUM;

    // Index width that never collapses to zero bits for a single-entry range
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [31:0] bin_of(input logic [31:0] data, input int np, input int bin_w);
        return data >> (np - bin_w);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int cnt_w);
        logic [31:0] max_v;
        max_v = (32'd1 << cnt_w) - 32'd1;
        if (val >= max_v) begin
            return max_v;
        end else begin
            return val + 32'd1;
        end
    endfunction

endpackage

// File: rtl/his_ram.sv
// Simple dual-port histogram store: one synchronous read port, one write port.
module his_ram
    import his_pkg::*;
#(
    parameter int DEPTH_N = DEPTH,
    parameter int WIDTH   = CNT_W_DEF,
    parameter int AW      = idx_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH_N];

    // Read returns the pre-write value on a collision; the builder forwards around it
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        rdata <= mem_r[raddr];
    end

endmodule

// File: rtl/his_peak_builder.sv
// Bins round-robin TDC timestamps into per-pixel histograms, tracks each pixel's
// peak bin while binning, and streams one peak result per pixel at frame end.
module his_peak_builder
    import his_pkg::*;
#(
    parameter int NP          = NP_DEF,
    parameter int PIXEL_NUM   = PIXEL_NUM_DEF,
    parameter int ACQ_NUM     = 2,
    parameter int BIN_W       = BIN_W_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter bit IGNORE_ZERO = 1'b1
) (
    input  logic                        clk,
    input  logic                        res,
    input  logic                        wrEn,
    input  logic [NP-1:0]               data,
    output logic                        in_ready,
    output logic                        peak_valid,
    input  logic                        peak_ready,
    output logic [idx_w(PIXEL_NUM)-1:0] peak_pixel,
    output logic [BIN_W-1:0]            peak_bin,
    output logic [CNT_W-1:0]            peak_count,
    output logic                        frame_done
);

    localparam int NBINS  = 2**BIN_W;
    localparam int NWORDS = PIXEL_NUM * NBINS;
    localparam int PIX_W  = idx_w(PIXEL_NUM);
    localparam int ACQ_W  = idx_w(ACQ_NUM);
    localparam int AW     = idx_w(NWORDS);
    localparam int PEAK_N = 2**PIX_W;

    his_state_e       state_r, state_s;
    logic [AW-1:0]    clr_addr_r;
    logic             flush_cnt_r;
    logic [PIX_W-1:0] pix_cnt_r, drain_pix_r, load_idx_s;
    logic [ACQ_W-1:0] acq_cnt_r;
    logic             in_ready_s, clearing_s, load_s, accept_s, drain_last_s;
    logic             xfer_s, s0_valid_s, last_sample_s;
    logic [BIN_W-1:0] bin_s;
    logic [AW-1:0]    addr_s;
    logic             s1_valid_r, fwd_r;
    logic [AW-1:0]    s1_addr_r;
    logic [PIX_W-1:0] s1_pix_r;
    logic [BIN_W-1:0] s1_bin_r;
    logic [CNT_W-1:0] fwd_data_r, rd_data_s, cur_s, new_s;
    logic             we_s;
    logic [AW-1:0]    waddr_s;
    logic [CNT_W-1:0] wdata_s;
    logic [BIN_W-1:0] peak_bin_r [PEAK_N];
    logic [CNT_W-1:0] peak_cnt_r [PEAK_N];

    assign xfer_s        = wrEn && in_ready_s;
    assign last_sample_s = xfer_s && (pix_cnt_r == PIX_W'(PIXEL_NUM - 1)) && (acq_cnt_r == ACQ_W'(ACQ_NUM - 1));
    assign s0_valid_s    = xfer_s && !(IGNORE_ZERO && (data == {NP{1'b0}}));
    assign bin_s         = BIN_W'(bin_of(32'(data), NP, BIN_W));
    assign addr_s        = AW'(32'(pix_cnt_r) * 32'(NBINS) + 32'(bin_s));
    assign accept_s      = peak_valid && peak_ready;
    assign drain_last_s  = (drain_pix_r == PIX_W'(PIXEL_NUM - 1));
    assign in_ready      = in_ready_s;
    assign new_s         = CNT_W'(sat_inc(32'(cur_s), CNT_W));

    // State register
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_r <= CLEAR;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            CLEAR:   if (clr_addr_r == AW'(NWORDS - 1)) state_s = ACCUM; else state_s = CLEAR;
            ACCUM:   if (last_sample_s) state_s = FLUSH; else state_s = ACCUM;
            FLUSH:   if (flush_cnt_r) state_s = DRAIN; else state_s = FLUSH;
            DRAIN:   if (accept_s && drain_last_s) state_s = CLEAR; else state_s = DRAIN;
            default: state_s = CLEAR;
        endcase
    end

    // State-decoded controls
    always_comb begin
        in_ready_s = 1'b0;
        clearing_s = 1'b0;
        load_s     = 1'b0;
        load_idx_s = {PIX_W{1'b0}};
        case (state_r)
            CLEAR:   clearing_s = 1'b1;
            ACCUM:   in_ready_s = 1'b1;
            FLUSH:   load_s     = flush_cnt_r;
            DRAIN: begin
                load_s     = accept_s && !drain_last_s;
                load_idx_s = drain_pix_r + PIX_W'(1);
            end
            default: in_ready_s = 1'b0;
        endcase
    end

    // Clear sweep, flush delay and pixel/acquisition slot counters
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            clr_addr_r  <= {AW{1'b0}};
            flush_cnt_r <= 1'b0;
            pix_cnt_r   <= {PIX_W{1'b0}};
            acq_cnt_r   <= {ACQ_W{1'b0}};
        end else begin
            clr_addr_r  <= (clearing_s && state_s == CLEAR) ? clr_addr_r + AW'(1) : {AW{1'b0}};
            flush_cnt_r <= (state_r == FLUSH) ? ~flush_cnt_r : 1'b0;
            if (xfer_s) begin
                if (pix_cnt_r == PIX_W'(PIXEL_NUM - 1)) begin
                    pix_cnt_r <= {PIX_W{1'b0}};
                    acq_cnt_r <= (acq_cnt_r == ACQ_W'(ACQ_NUM - 1)) ? {ACQ_W{1'b0}} : acq_cnt_r + ACQ_W'(1);
                end else begin
                    pix_cnt_r <= pix_cnt_r + PIX_W'(1);
                end
            end
        end
    end

    // Stage-1 operand: a write still in flight to the same bin wins over the RAM read
    always_comb begin
        if (fwd_r) begin
            cur_s = fwd_data_r;
        end else begin
            cur_s = rd_data_s;
        end
    end

    // Stage 0 -> stage 1 pipeline registers; skipped samples become bubbles
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            s1_valid_r <= 1'b0;
            s1_addr_r  <= {AW{1'b0}};
            s1_pix_r   <= {PIX_W{1'b0}};
            s1_bin_r   <= {BIN_W{1'b0}};
            fwd_r      <= 1'b0;
            fwd_data_r <= {CNT_W{1'b0}};
        end else begin
            s1_valid_r <= s0_valid_s;
            s1_addr_r  <= addr_s;
            s1_pix_r   <= pix_cnt_r;
            s1_bin_r   <= bin_s;
            fwd_r      <= s0_valid_s && s1_valid_r && (addr_s == s1_addr_r);
            fwd_data_r <= new_s;
        end
    end

    // RAM write port: zero sweep during CLEAR, incremented count otherwise
    always_comb begin
        if (clearing_s) begin
            we_s    = 1'b1;
            waddr_s = clr_addr_r;
            wdata_s = {CNT_W{1'b0}};
        end else begin
            we_s    = s1_valid_r;
            waddr_s = s1_addr_r;
            wdata_s = new_s;
        end
    end

    his_ram #(
        .DEPTH_N (NWORDS),
        .WIDTH   (CNT_W),
        .AW      (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (wdata_s),
        .raddr (addr_s),
        .rdata (rd_data_s)
    );

    // Running per-pixel peak: strictly greater wins, so ties keep the earlier bin
    always_ff @(posedge clk or negedge res) begin
        if (!res || clearing_s) begin
            for (int i = 0; i < PEAK_N; i++) begin
                peak_bin_r[i] <= {BIN_W{1'b0}};
                peak_cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else if (s1_valid_r && (new_s > peak_cnt_r[s1_pix_r])) begin
            peak_bin_r[s1_pix_r] <= s1_bin_r;
            peak_cnt_r[s1_pix_r] <= new_s;
        end
    end

    // Result stream; holds while peak_valid && !peak_ready
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            peak_valid  <= 1'b0;
            peak_pixel  <= {PIX_W{1'b0}};
            peak_bin    <= {BIN_W{1'b0}};
            peak_count  <= {CNT_W{1'b0}};
            drain_pix_r <= {PIX_W{1'b0}};
            frame_done  <= 1'b0;
        end else if (load_s) begin
            peak_valid  <= 1'b1;
            peak_pixel  <= load_idx_s;
            peak_bin    <= peak_bin_r[load_idx_s];
            peak_count  <= peak_cnt_r[load_idx_s];
            drain_pix_r <= load_idx_s;
            frame_done  <= 1'b0;
        end else if (accept_s && drain_last_s) begin
            peak_valid  <= 1'b0;
            peak_pixel  <= {PIX_W{1'b0}};
            peak_bin    <= {BIN_W{1'b0}};
            peak_count  <= {CNT_W{1'b0}};
            drain_pix_r <= {PIX_W{1'b0}};
            frame_done  <= 1'b1;
        end else begin
            frame_done  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_his_peak_builder.sv
// Self-checking bench for his_peak_builder: default geometry plus two single-pixel variants.
module tb_his_peak_builder;

    typedef struct packed {
        logic [1:0] pix;
        logic [3:0] bin;
        logic [7:0] cnt;
    } res_t;

    typedef struct packed {
        logic [5:0][9:0] d;
        logic [2:0][3:0] b;
        logic [2:0][7:0] c;
    } vec_t;

    logic clk = 1'b0;
    logic res;
    logic wrEn, in_ready, peak_valid, peak_ready, frame_done;
    logic [9:0] data;
    logic [1:0] peak_pixel;
    logic [3:0] peak_bin;
    logic [7:0] peak_count;
    logic wrEn4, in_ready4, peak_valid4, peak_ready4, frame_done4;
    logic [9:0] data4;
    logic [0:0] peak_pixel4;
    logic [3:0] peak_bin4;
    logic [1:0] peak_count4;
    logic wrEn5, in_ready5, peak_valid5, peak_ready5, frame_done5;
    logic [9:0] data5;
    logic [0:0] peak_pixel5;
    logic [3:0] peak_bin5;
    logic [7:0] peak_count5;

    int   n_tests = 0;
    int   n_fail  = 0;
    res_t sb[$];
    vec_t vecs[5];

    always #5 clk = ~clk;

    his_peak_builder dut (
        .clk(clk), .res(res), .wrEn(wrEn), .data(data), .in_ready(in_ready),
        .peak_valid(peak_valid), .peak_ready(peak_ready), .peak_pixel(peak_pixel),
        .peak_bin(peak_bin), .peak_count(peak_count), .frame_done(frame_done)
    );

    his_peak_builder #(.PIXEL_NUM(1), .ACQ_NUM(5), .CNT_W(2)) dut4 (
        .clk(clk), .res(res), .wrEn(wrEn4), .data(data4), .in_ready(in_ready4),
        .peak_valid(peak_valid4), .peak_ready(peak_ready4), .peak_pixel(peak_pixel4),
        .peak_bin(peak_bin4), .peak_count(peak_count4), .frame_done(frame_done4)
    );

    his_peak_builder #(.PIXEL_NUM(1), .ACQ_NUM(4)) dut5 (
        .clk(clk), .res(res), .wrEn(wrEn5), .data(data5), .in_ready(in_ready5),
        .peak_valid(peak_valid5), .peak_ready(peak_ready5), .peak_pixel(peak_pixel5),
        .peak_bin(peak_bin5), .peak_count(peak_count5), .frame_done(frame_done5)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int d0, input int d1, input int d2, input int d3,
                                input int d4, input int d5, input int b0, input int b1,
                                input int b2, input int c0, input int c1, input int c2);
        vec_t v;
        v.d[0] = 10'(d0); v.d[1] = 10'(d1); v.d[2] = 10'(d2);
        v.d[3] = 10'(d3); v.d[4] = 10'(d4); v.d[5] = 10'(d5);
        v.b[0] = 4'(b0);  v.b[1] = 4'(b1);  v.b[2] = 4'(b2);
        v.c[0] = 8'(c0);  v.c[1] = 8'(c1);  v.c[2] = 8'(c2);
        return v;
    endfunction

    // Drive one 6-sample frame on the default DUT, then drain and score its results
    task automatic run_frame(input vec_t v, input int stall_pix, input int stall_n);
        int w, got, fd, fd_cyc, stalled, end_cyc;
        logic [14:0] snap, now_v;
        res_t e, a;
        w = 0; got = 0; fd = 0; fd_cyc = -1000; stalled = 0; end_cyc = -1; snap = 15'd0;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", 32'(in_ready), 32'd1);
        for (int p = 0; p < 3; p++) begin
            e.pix = 2'(p); e.bin = v.b[p]; e.cnt = v.c[p];
            sb.push_back(e);
        end
        for (int i = 0; i < 6; i++) begin
            chk("in_ready_accum", 32'(in_ready), 32'd1);
            wrEn = 1'b1;
            data = v.d[i];
            @(negedge clk);
        end
        wrEn = 1'b0;
        chk("in_ready_drop", 32'(in_ready), 32'd0);
        for (int cyc = 0; cyc < 150; cyc++) begin
            end_cyc = cyc;
            if (frame_done) begin
                fd++;
                if (fd_cyc < 0) fd_cyc = cyc;
            end
            now_v = {peak_valid, peak_pixel, peak_bin, peak_count};
            if (peak_valid && peak_pixel == 2'(stall_pix) && stalled < stall_n) begin
                peak_ready = 1'b0;
                if (stalled > 0) chk("stall_stable", 32'(now_v), 32'(snap));
                snap = now_v;
                stalled++;
            end else if (peak_valid) begin
                peak_ready = 1'b1;
                a = {peak_pixel, peak_bin, peak_count};
                if (sb.size() == 0) begin
                    chk("sb_extra_result", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("peak_result", 32'(a), 32'(e));
                    got++;
                end
            end else begin
                peak_ready = 1'b0;
            end
            if (in_ready) break;
            @(negedge clk);
        end
        peak_ready = 1'b0;
        chk("results_count", 32'(got), 32'd3);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("frame_done_pulses", 32'(fd), 32'd1);
        chk("clear_cycles", 32'(end_cyc - fd_cyc), 32'd48);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise, r4, r5, w, seen, fdp;
        logic dirty;
        res = 1'b0;
        wrEn = 1'b0; data = 10'd0; peak_ready = 1'b0;
        wrEn4 = 1'b0; data4 = 10'd0; peak_ready4 = 1'b0;
        wrEn5 = 1'b0; data5 = 10'd0; peak_ready5 = 1'b0;
        vecs[0] = mk(108, 1023, 0, 300, 1023, 0,   1, 15, 0,  1, 2, 0);
        vecs[1] = mk(108, 108, 108, 108, 108, 108, 1, 1, 1,   2, 2, 2);
        vecs[2] = mk(0, 0, 0, 0, 0, 0,             0, 0, 0,   0, 0, 0);
        vecs[3] = mk(64, 1023, 5, 1000, 960, 63,   1, 15, 0,  1, 2, 2);
        vecs[4] = mk(700, 0, 1, 700, 200, 0,       10, 3, 0,  2, 1, 1);

        // Reset state and CLEAR length
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({in_ready, peak_valid, frame_done, peak_pixel, peak_bin, peak_count}), 32'd0);
        res = 1'b1;
        rise = -1; r4 = -1; r5 = -1; dirty = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (in_ready && rise < 0) rise = i;
            if (in_ready4 && r4 < 0) r4 = i;
            if (in_ready5 && r5 < 0) r5 = i;
            if (!in_ready && (peak_valid || frame_done || peak_pixel != 2'd0 || peak_bin != 4'd0 || peak_count != 8'd0))
                dirty = 1'b1;
        end
        chk("clear_len", 32'(rise), 32'd48);
        chk("clear_len_p1_a", 32'(r4), 32'd16);
        chk("clear_len_p1_b", 32'(r5), 32'd16);
        chk("outputs_zero_in_clear", 32'(dirty), 32'd0);

        // Table-driven frames, then the stalled-drain variant of the first one
        for (int k = 0; k < 5; k++) run_frame(vecs[k], -1, 0);
        run_frame(vecs[0], 1, 5);

        // Abort a frame with reset; the next frame must show no residue
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        for (int i = 0; i < 3; i++) begin
            wrEn = 1'b1; data = 10'd108;
            @(negedge clk);
        end
        wrEn = 1'b0;
        res = 1'b0;
        #1;
        chk("abort_outputs", 32'({in_ready, peak_valid, frame_done, peak_pixel, peak_bin, peak_count}), 32'd0);
        @(negedge clk);
        res = 1'b1;
        run_frame(vecs[1], -1, 0);

        // Saturation: one pixel, 2-bit counters, five hits on bin 7
        @(negedge clk);
        w = 0;
        while (!in_ready4 && w < 100) begin
            @(negedge clk);
            w++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("sat_in_ready", 32'(in_ready4), 32'd1);
            wrEn4 = 1'b1; data4 = 10'd500;
            @(negedge clk);
        end
        wrEn4 = 1'b0; peak_ready4 = 1'b1;
        chk("sat_in_ready_drop", 32'(in_ready4), 32'd0);
        seen = 0; fdp = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (frame_done4) fdp++;
            if (peak_valid4 && seen == 0) begin
                seen = 1;
                chk("sat_peak", 32'({peak_pixel4, peak_bin4, peak_count4}), 32'({1'b0, 4'd7, 2'd3}));
            end
        end
        chk("sat_seen", 32'(seen), 32'd1);
        chk("sat_frame_done", 32'(fdp), 32'd1);

        // Forwarding: one pixel, four back-to-back hits on bin 1
        w = 0;
        while (!in_ready5 && w < 100) begin
            @(negedge clk);
            w++;
        end
        for (int i = 0; i < 4; i++) begin
            chk("fwd_in_ready", 32'(in_ready5), 32'd1);
            wrEn5 = 1'b1; data5 = 10'd64;
            @(negedge clk);
        end
        wrEn5 = 1'b0; peak_ready5 = 1'b1;
        seen = 0; fdp = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (frame_done5) fdp++;
            if (peak_valid5 && seen == 0) begin
                seen = 1;
                chk("fwd_peak", 32'({peak_pixel5, peak_bin5, peak_count5}), 32'({1'b0, 4'd1, 8'd4}));
            end
        end
        chk("fwd_seen", 32'(seen), 32'd1);
        chk("fwd_frame_done", 32'(fdp), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/his_peak_builder.md
Name: his_peak_builder

Overview:
- Parametrised successor to the fixed-size histogram FSM in the dToF pipeline.
- Accepts a round-robin stream of TDC timestamps (one per pixel per acquisition) and bins them into per-pixel histograms held in internal RAM.
- Tracks each pixel's peak bin on the fly while binning.
- After ACQ_NUM acquisitions, streams out one (pixel, peak bin, peak count) result per pixel over a valid/ready handshake, then self-clears for the next frame.

Parameters:
- NP, 10: timestamp width in bits.
- PIXEL_NUM, 3: pixels interleaved in the stream.
- ACQ_NUM, 2: acquisitions per frame.
- BIN_W, 4: histogram index width; BIN_NUM = 2**BIN_W; bin = data >> (NP-BIN_W).
- CNT_W, 8: bin counter width; counters saturate.
- IGNORE_ZERO, 1: when 1, data==0 means "no photon"; the pixel slot advances but no bin is incremented.

Ports:
- clk  in  1  system clock.
- res  in  1  asynchronous active-low reset.
- wrEn  in  1  input sample valid.
- data  in  NP  timestamp for the current pixel slot.
- in_ready  out  1  block accepts a sample this cycle; a transfer occurs when wrEn && in_ready.
- peak_valid  out  1  result available.
- peak_ready  in  1  downstream accepts result.
- peak_pixel  out  $clog2(PIXEL_NUM)  pixel index of the result.
- peak_bin  out  BIN_W  bin holding the maximum count.
- peak_count  out  CNT_W  maximum count.
- frame_done  out  1  single-cycle pulse when the last result is accepted.

Behaviour:
- Reset (res=0, async): all outputs are 0, including in_ready, peak_valid and frame_done. Pixel counter, acquisition counter and peak registers are zeroed. State goes to CLEAR.
- Reset mid-operation: any partial frame is discarded.
- States:
  - CLEAR: writes 0 to addresses 0..PIXEL_NUM*BIN_NUM-1, one per cycle; in_ready=0. Goes to ACCUM after the last address.
  - ACCUM: in_ready=1. Each transfer targets pixel pix_cnt. pix_cnt wraps at PIXEL_NUM-1 and then increments acq_cnt. The transfer with pix_cnt=PIXEL_NUM-1 and acq_cnt=ACQ_NUM-1 is the frame's last sample: in_ready drops the next cycle and the state goes to FLUSH.
  - FLUSH: waits until the 2-stage pipeline is empty (2 cycles), then goes to DRAIN.
  - DRAIN: presents pixel 0..PIXEL_NUM-1 in order. Outputs are held stable while peak_valid && !peak_ready. On the last accept, frame_done pulses and the state goes to CLEAR.
- Pipeline, per transfer:
  - Stage 0: addr = pix*BIN_NUM + bin; RAM read issued.
  - Stage 1: new = sat(rd+1); write new; peak update.
  - Samples skipped by IGNORE_ZERO travel down the pipeline as bubbles: no write, no peak update.
- Hazard: if stage-1 and stage-0 addresses are equal (possible only when PIXEL_NUM==1), stage 0 uses the forwarded stage-1 write value, not the RAM read. Back-to-back same-bin hits must count exactly.
- Saturation: a counter at 2**CNT_W-1 stays there.
- Peak rule:
  - Update when new > peak_count[pix].
  - On a tie the earlier-reached bin is kept.
  - A pixel with no hits reports bin 0, count 0.
- Peak registers are cleared when CLEAR is entered.
- Throughput: 1 sample/cycle in ACCUM; no stalls other than the state gating above.

Decomposition:
- Package his_pkg holds:
  - state enum {CLEAR, ACCUM, FLUSH, DRAIN};
  - function bin_of(data) for the shift;
  - localparams BIN_NUM and DEPTH = PIXEL_NUM*BIN_NUM;
  - a saturating-increment function.
- One sub-module, his_ram: simple dual-port RAM, DEPTH x CNT_W, synchronous 1-cycle read, one read and one write port. Keeps the RAM inferable.

Test Plan:
1. Defaults; release res and hold wrEn=0 -> in_ready rises exactly 48 cycles after res deasserts (3 pixels * 16 bins); all outputs 0 before that.
2. Defaults; stream 108,1023,0,300,1023,0 -> results in order:
   - p0: bin 1, count 1 (tie with bin 4, first-reached kept);
   - p1: bin 15, count 2;
   - p2: bin 0, count 0;
   - frame_done pulses once; in_ready returns after 48 CLEAR cycles.
3. Case 2 with peak_ready held low for 5 cycles on p1 -> peak_pixel, peak_bin and peak_count stay stable (1, 15, 2) with peak_valid high; no result is lost or duplicated.
4. CNT_W=2, ACQ_NUM=5, PIXEL_NUM=1; data 500 every cycle -> bin 7, count 3 (saturated).
5. PIXEL_NUM=1, ACQ_NUM=4; data 64 on four consecutive cycles -> bin 1, count 4 (forwarding verified).
6. Defaults; assert res low after 3 samples of a frame -> outputs go to 0 immediately. After CLEAR, a fresh frame of 108 for all 6 samples -> every pixel reports bin 1, count 2 (no residue from the aborted frame).
